// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: sync/blank/coordinates/markers plus a
// four-way pixel source (grid, bars, stream with underflow tracking, solid).
module vga_timing_gen #(
  parameter int HDISP    = 800,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VDISP    = 480,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29,
  parameter int SYNC_POL = 0
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [23:0]                solid_rgb,
  input  logic [23:0]                pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic                       hs,
  output logic                       vs,
  output logic                       blank,
  output logic [23:0]                rgb,
  output logic [$clog2(HDISP)-1:0]   x,
  output logic [$clog2(VDISP)-1:0]   y,
  output logic                       sof,
  output logic                       sol,
  output logic                       underflow,
  input  logic                       underflow_clr
);

  localparam int HBLK   = HFP + HPULSE + HBP;
  localparam int HTOTAL = HBLK + HDISP;
  localparam int VBLK   = VFP + VPULSE + VBP;
  localparam int VTOTAL = VBLK + VDISP;
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic          SP      = (SYNC_POL != 0);
  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_BLK   = HW'(HBLK);
  localparam logic [HW-1:0] H_SYNC0 = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC1 = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_BLK   = VW'(VBLK);
  localparam logic [VW-1:0] V_SYNC0 = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC1 = VW'(VFP + VPULSE);

  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;
  logic [1:0]    mode_q;
  logic          active_p0;
  logic          hsync_p0;
  logic          vsync_p0;
  logic [XW-1:0] x_p0;
  logic [YW-1:0] y_p0;
  logic [23:0]   rgb_p0;
  logic          uf_set_p0;

  function automatic logic [23:0] grid_rgb(input logic [XW-1:0] xv, input logic [YW-1:0] yv);
    logic [31:0] xe;
    logic [31:0] ye;
    xe = 32'(xv);
    ye = 32'(yv);
    return ((xe[3:0] == 4'hf) || (ye[3:0] == 4'hf)) ? 24'hffffff : 24'h000000;
  endfunction

  // Bar index is the highest boundary passed; boundaries are elaboration constants.
  function automatic logic [23:0] bar_rgb(input logic [XW-1:0] xv);
    logic [31:0]    xe;
    logic [2:0]     idx;
    logic [23:0]    col;
    xe  = 32'(xv);
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (xe >= 32'(i * HDISP / 8)) idx = 3'(i);
    end
    case (idx)
      3'd0:    col = 24'hffffff;
      3'd1:    col = 24'hffff00;
      3'd2:    col = 24'h00ffff;
      3'd3:    col = 24'h00ff00;
      3'd4:    col = 24'hff00ff;
      3'd5:    col = 24'hff0000;
      3'd6:    col = 24'h0000ff;
      default: col = 24'h000000;
    endcase
    return col;
  endfunction

  // Stage p0: decode of the current counter position
  always_comb begin
    active_p0 = enable && (h_p0 >= H_BLK) && (v_p0 >= V_BLK);
    hsync_p0  = (h_p0 >= H_SYNC0) && (h_p0 < H_SYNC1);
    vsync_p0  = (v_p0 >= V_SYNC0) && (v_p0 < V_SYNC1);
    x_p0      = '0;
    y_p0      = '0;
    rgb_p0    = 24'h000000;
    if (active_p0) begin
      x_p0 = XW'(h_p0 - H_BLK);
      y_p0 = YW'(v_p0 - V_BLK);
      case (mode_q)
        2'd0:    rgb_p0 = grid_rgb(x_p0, y_p0);
        2'd1:    rgb_p0 = bar_rgb(x_p0);
        2'd2:    rgb_p0 = pix_valid ? pix_data : 24'h000000;
        default: rgb_p0 = solid_rgb;
      endcase
    end
    pix_ready = active_p0 && (mode_q == 2'd2);
    uf_set_p0 = active_p0 && (mode_q == 2'd2) && !pix_valid;
  end

  // Stage p1: registered timing and pixel outputs
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_p0   <= '0;
      v_p0   <= '0;
      mode_q <= 2'd0;
      hs     <= ~SP;
      vs     <= ~SP;
      blank  <= 1'b0;
      rgb    <= 24'h000000;
      x      <= '0;
      y      <= '0;
      sof    <= 1'b0;
      sol    <= 1'b0;
    end else if (!enable) begin
      h_p0   <= '0;
      v_p0   <= '0;
      mode_q <= 2'd0;
      hs     <= ~SP;
      vs     <= ~SP;
      blank  <= 1'b0;
      rgb    <= 24'h000000;
      x      <= '0;
      y      <= '0;
      sof    <= 1'b0;
      sol    <= 1'b0;
    end else begin
      if (h_p0 == H_LAST) begin
        h_p0 <= '0;
        v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + VW'(1);
      end else begin
        h_p0 <= h_p0 + HW'(1);
      end
      // Source select only changes at the frame origin so a frame never tears.
      if ((h_p0 == '0) && (v_p0 == '0)) mode_q <= mode;
      hs    <= hsync_p0 ? SP : ~SP;
      vs    <= vsync_p0 ? SP : ~SP;
      blank <= active_p0;
      rgb   <= rgb_p0;
      x     <= x_p0;
      y     <= y_p0;
      sol   <= active_p0 && (h_p0 == H_BLK);
      sof   <= active_p0 && (h_p0 == H_BLK) && (v_p0 == V_BLK);
    end
  end

  // Underflow survives enable=0; a new miss wins over a clear in the same cycle.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n)       underflow <= 1'b0;
    else if (uf_set_p0)     underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small timing config (A) and 32x32 pattern/stream
// config with inverted sync polarity (B), checked against a position-based model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Config A: 8x4 active, porches 2/2/2 and 1/1/1, frame of 98 cycles
  logic        en_a = 1'b0;
  logic [1:0]  mode_a = 2'd0;
  logic [23:0] solid_a = 24'h0;
  logic [23:0] pdata_a = 24'h0;
  logic        pvalid_a = 1'b0;
  logic        clr_a = 1'b0;
  logic        rdy_a, hs_a, vs_a, blank_a, sof_a, sol_a, uf_a;
  logic [23:0] rgb_a;
  logic [2:0]  x_a;
  logic [1:0]  y_a;

  // Config B: 32x32 active, same porches, SYNC_POL=1, frame of 38*35 cycles
  logic        en_b = 1'b0;
  logic [1:0]  mode_b = 2'd0;
  logic [23:0] solid_b = 24'h123456;
  logic [23:0] pdata_b = 24'h0;
  logic        pvalid_b = 1'b0;
  logic        clr_b = 1'b0;
  logic        rdy_b, hs_b, vs_b, blank_b, sof_b, sol_b, uf_b;
  logic [23:0] rgb_b;
  logic [4:0]  x_b;
  logic [4:0]  y_b;

  vga_timing_gen #(
    .HDISP(8), .HFP(2), .HPULSE(2), .HBP(2),
    .VDISP(4), .VFP(1), .VPULSE(1), .VBP(1), .SYNC_POL(0)
  ) dut_a (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(en_a), .mode(mode_a),
    .solid_rgb(solid_a), .pix_data(pdata_a), .pix_valid(pvalid_a),
    .pix_ready(rdy_a), .hs(hs_a), .vs(vs_a), .blank(blank_a), .rgb(rgb_a),
    .x(x_a), .y(y_a), .sof(sof_a), .sol(sol_a), .underflow(uf_a),
    .underflow_clr(clr_a)
  );

  vga_timing_gen #(
    .HDISP(32), .HFP(2), .HPULSE(2), .HBP(2),
    .VDISP(32), .VFP(1), .VPULSE(1), .VBP(1), .SYNC_POL(1)
  ) dut_b (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(en_b), .mode(mode_b),
    .solid_rgb(solid_b), .pix_data(pdata_b), .pix_valid(pvalid_b),
    .pix_ready(rdy_b), .hs(hs_b), .vs(vs_b), .blank(blank_b), .rgb(rgb_b),
    .x(x_b), .y(y_b), .sof(sof_b), .sol(sol_b), .underflow(uf_b),
    .underflow_clr(clr_b)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] sb_q[$];

  int pa = 0;
  int pb = 0;
  logic [1:0] mm = 2'd0;
  logic uf = 1'b0;
  int dcnt = 0;
  int beats = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [23:0] grid_exp(input int xi, input int yi);
    return ((xi % 16 == 15) || (yi % 16 == 15)) ? 24'hFFFFFF : 24'h000000;
  endfunction

  function automatic logic [23:0] bar_exp(input int xi);
    int i;
    i = xi / 4;
    if (i > 7) i = 7;
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [63:0] obs_a();
    return 64'({hs_a, vs_a, blank_a, sof_a, sol_a, x_a, y_a, rgb_a, uf_a});
  endfunction

  function automatic logic [63:0] obs_b();
    return 64'({hs_b, vs_b, blank_b, sof_b, sol_b, x_b, y_b, rgb_b, uf_b});
  endfunction

  function automatic logic [63:0] idle_a();
    return 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 24'h0, 1'b0});
  endfunction

  function automatic logic [63:0] idle_b(input logic u);
    return 64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 24'h0, u});
  endfunction

  function automatic logic [63:0] model_a(input int p);
    int h, v, xi, yi;
    logic act;
    h   = p % 14;
    v   = p / 14;
    act = (h >= 6) && (v >= 3);
    xi  = act ? h - 6 : 0;
    yi  = act ? v - 3 : 0;
    return 64'({!((h >= 2) && (h < 4)), !(v == 1), act, act && h == 6 && v == 3,
                act && h == 6, 3'(xi), 2'(yi),
                act ? grid_exp(xi, yi) : 24'h0, 1'b0});
  endfunction

  task automatic step_a();
    sb_q.push_back(en_a ? model_a(pa) : idle_a());
    @(posedge clk);
    #1;
    pa = en_a ? (pa + 1) % 98 : 0;
    chk("a_out", obs_a(), sb_q.pop_front());
  endtask

  task automatic step_b(input logic valid, input logic clr);
    int h, v, xi, yi;
    logic act, rdy;
    logic [23:0] er;
    pvalid_b = valid;
    clr_b    = clr;
    pdata_b  = 24'h100000 + 24'(dcnt);
    #1;
    h = pb % 38;
    v = pb / 38;
    if (!en_b) mm = 2'd0;
    else if (pb == 0) mm = mode_b;
    act = en_b && (h >= 6) && (v >= 3);
    rdy = act && (mm == 2'd2);
    chk("b_ready", 64'(rdy_b), 64'(rdy));
    if (rdy_b && valid) beats++;
    xi = act ? h - 6 : 0;
    yi = act ? v - 3 : 0;
    er = 24'h0;
    if (act) begin
      case (mm)
        2'd0: er = grid_exp(xi, yi);
        2'd1: er = bar_exp(xi);
        2'd2: er = valid ? pdata_b : 24'h0;
        default: er = solid_b;
      endcase
    end
    if (act && mm == 2'd2 && !valid) uf = 1'b1;
    else if (clr) uf = 1'b0;
    if (rdy && valid) dcnt++;
    if (en_b)
      sb_q.push_back(64'({(h >= 2) && (h < 4), v == 1, act, act && h == 6 && v == 3,
                          act && h == 6, 5'(xi), 5'(yi), er, uf}));
    else
      sb_q.push_back(idle_b(uf));
    @(posedge clk);
    #1;
    pb = en_b ? (pb + 1) % 1330 : 0;
    chk("b_out", obs_b(), sb_q.pop_front());
  endtask

  initial begin
    int nhs, nvs, nblank, nsof, nsol, first_hs, beats_line;

    // Reset state on both configurations
    #12;
    chk("a_reset", obs_a(), idle_a());
    chk("a_reset_ready", 64'(rdy_a), 64'(0));
    chk("b_reset", obs_b(), idle_b(1'b0));
    rst_n = 1'b1;
    repeat (3) step_a();

    // Config A: three free-running frames with per-cycle model and totals
    nhs = 0; nvs = 0; nblank = 0; nsof = 0; nsol = 0;
    en_a = 1'b1;
    for (int k = 0; k < 3 * 98; k++) begin
      step_a();
      if (!hs_a) nhs++;
      if (!vs_a) nvs++;
      if (blank_a) nblank++;
      if (sof_a) nsof++;
      if (sol_a) nsol++;
    end
    chk("a_hs_low_cycles", 64'(nhs), 64'(42));
    chk("a_vs_low_cycles", 64'(nvs), 64'(42));
    chk("a_blank_cycles", 64'(nblank), 64'(96));
    chk("a_sof_count", 64'(nsof), 64'(3));
    chk("a_sol_count", 64'(nsol), 64'(12));

    // Enable drop mid-frame, then restart: first hs pulse at the cold-start offset
    repeat (20) step_a();
    en_a = 1'b0;
    repeat (3) step_a();
    en_a = 1'b1;
    first_hs = -1;
    for (int k = 0; k < 30; k++) begin
      step_a();
      if (!hs_a && first_hs < 0) first_hs = k;
    end
    chk("a_restart_hs_offset", 64'(first_hs), 64'(2));

    // Asynchronous reset in the middle of an active line
    repeat (21) step_a();
    chk("a_midline_active", 64'(blank_a), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_async_reset", obs_a(), idle_a());
    en_a = 1'b0;
    pa = 0;
    #1;
    rst_n = 1'b1;

    // Config B idle with SYNC_POL=1: sync lines rest low
    repeat (3) step_b(1'b0, 1'b0);

    // Frame 1 grid; mode 3 requested mid-frame
    en_b = 1'b1;
    for (int k = 0; k < 1330; k++) begin
      if (k == 600) mode_b = 2'd3;
      step_b(1'b1, 1'b0);
    end
    // Frame 2 solid; bars requested mid-frame
    for (int k = 0; k < 1330; k++) begin
      if (k == 600) mode_b = 2'd1;
      step_b(1'b1, 1'b0);
    end
    // Frame 3 bars; stream requested mid-frame
    for (int k = 0; k < 1330; k++) begin
      if (k == 600) mode_b = 2'd2;
      step_b(1'b1, 1'b0);
    end
    // Frame 4 stream: blank-time valid drop, active drops, set+clear collision, clear
    beats = 0;
    beats_line = 0;
    for (int k = 0; k < 1330; k++) begin
      if (k == 152) beats_line = beats;
      if (k == 50 || k == 200 || k == 1000) step_b(1'b0, 1'b0);
      else if (k == 400) step_b(1'b0, 1'b1);
      else if (k == 500) step_b(1'b1, 1'b1);
      else step_b(1'b1, 1'b0);
      if (k == 50) chk("b_blank_valid_ignored", 64'(uf_b), 64'(0));
      if (k == 200) chk("b_underflow_set", 64'(uf_b), 64'(1));
      if (k == 400) chk("b_set_beats_clear", 64'(uf_b), 64'(1));
      if (k == 500) chk("b_underflow_cleared", 64'(uf_b), 64'(0));
    end
    chk("b_beats_first_line", 64'(beats_line), 64'(32));
    chk("b_beats_frame", 64'(beats), 64'(1021));

    // Disable keeps the sticky flag; only reset clears it
    en_b = 1'b0;
    repeat (2) step_b(1'b1, 1'b0);
    chk("b_uf_held_disabled", 64'(uf_b), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    uf = 1'b0;
    chk("b_async_reset", obs_b(), idle_b(1'b0));
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
